fma16_align: RTL and testbench

Pipelined addend alignment stage for the fma16 datapath: the right-shift counterpart of the post-add normalizer. It takes the x/y exponents and the z operand, computes the product exponent and alignment count, and right-shifts z's significand into the 36-bit sum field with sticky collection. It sits between operand unpack and the 36-bit adder, feeding the leading-zero count and normalize stage.

---
 rtl/fma16_pkg.sv | 27 ++
 rtl/fma16_align_if.sv | 28 ++
 rtl/fma16_align_rshift_sticky.sv | 27 ++
 rtl/fma16_align.sv | 83 ++++++++
 tb/tb_fma16_align.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fma16_pkg.sv
// Shared constants and stage payloads for the fma16 datapath (align and normalize sides).
package fma16_pkg;

    localparam int unsigned NE        = 5;
    localparam int unsigned NF        = 10;
    localparam int unsigned BIAS      = 15;
    localparam int unsigned SUM_W     = 3 * NF + 6;
    localparam int unsigned ACNT_W    = 8;
    localparam int unsigned ALIGN_OFS = 12;
    localparam int unsigned PAD_W     = 25;
    localparam int unsigned MAN_W     = NF + 1;
    localparam int unsigned PE_W      = 7;

    typedef struct packed {
        logic [PE_W-1:0]   pe;
        logic [ACNT_W-1:0] acnt;
        logic [MAN_W-1:0]  zm;
    } align_s1_t;

    typedef struct packed {
        logic [PE_W-1:0]  pe;
        logic [SUM_W-1:0] am;
        logic             asticky;
        logic             killprod;
    } align_s2_t;

endpackage

// File: rtl/fma16_align_if.sv
// Operand-in / aligned-addend-out handshake bundle for fma16_align.
interface fma16_align_if;
    import fma16_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [NE-1:0]    Xe;
    logic [NE-1:0]    Ye;
    logic [NE-1:0]    Ze;
    logic [MAN_W-1:0] Zm;
    logic             out_valid;
    logic             out_ready;
    logic [PE_W-1:0]  Pe;
    logic [SUM_W-1:0] Am;
    logic             ASticky;
    logic             KillProd;

    modport slave (
        input  in_valid, Xe, Ye, Ze, Zm, out_ready,
        output in_ready, out_valid, Pe, Am, ASticky, KillProd
    );

    modport master (
        output in_valid, Xe, Ye, Ze, Zm, out_ready,
        input  in_ready, out_valid, Pe, Am, ASticky, KillProd
    );

endinterface

// File: rtl/fma16_align_rshift_sticky.sv
// Saturating logical right shift with sticky collection of the bits shifted out.
// Sticky reduction exists only when FMA16_ALIGN_STICKY_EN is defined.
module rshift_sticky
    import fma16_pkg::*;
(
    input  logic [SUM_W-1:0]  i_val,
    input  logic [ACNT_W-1:0] i_shamt,
    output logic [SUM_W-1:0]  o_val,
    output logic              o_sticky
);

    logic w_sat;

    assign w_sat = (i_shamt >= ACNT_W'(SUM_W));
    assign o_val = w_sat ? '0 : (i_val >> i_shamt);

`ifdef FMA16_ALIGN_STICKY_EN
    logic [SUM_W-1:0] w_lost_mask;

    // Ones in the positions that fall off the bottom of the field
    assign w_lost_mask = ~({SUM_W{1'b1}} << i_shamt);
    assign o_sticky    = w_sat ? (|i_val) : (|(i_val & w_lost_mask));
`else
    assign o_sticky    = 1'b0;
`endif

endmodule

// File: rtl/fma16_align.sv
// Two-stage addend alignment: S1 computes Pe/Acnt, S2 shifts {Zm,pad} into the sum field.
// Optional sticky collection under FMA16_ALIGN_STICKY_EN.
module fma16_align
    import fma16_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    fma16_align_if.slave  io_bus
);

    logic             r_v1;
    logic             r_v2;
    align_s1_t        r_s1;
    align_s2_t        r_s2;
    align_s1_t        w_s1;
    align_s2_t        w_s2;
    logic             w_en1;
    logic             w_en2;
    logic [PE_W-1:0]  w_pe;
    logic [ACNT_W-1:0] w_acnt;
    logic             w_neg;
    logic [SUM_W-1:0] w_field;
    logic [ACNT_W-1:0] w_shamt;
    logic [SUM_W-1:0] w_shifted;
    logic             w_sticky;

    assign w_en2           = ~r_v2 | io_bus.out_ready;
    assign w_en1           = ~r_v1 | w_en2;
    assign io_bus.in_ready = w_en1;

    // Stage 1: product exponent and alignment count, both two's complement
    assign w_pe   = PE_W'(io_bus.Xe) + PE_W'(io_bus.Ye) - PE_W'(BIAS);
    assign w_acnt = {{(ACNT_W-PE_W){w_pe[PE_W-1]}}, w_pe}
                    - ACNT_W'(io_bus.Ze) + ACNT_W'(ALIGN_OFS);

    always_comb begin
        w_s1      = '0;
        w_s1.pe   = w_pe;
        w_s1.acnt = w_acnt;
        w_s1.zm   = io_bus.Zm;
    end

    // Stage 2: negative count means the addend dominates and is passed unshifted
    assign w_neg   = r_s1.acnt[ACNT_W-1];
    assign w_field = {r_s1.zm, PAD_W'(0)};
    assign w_shamt = w_neg ? '0 : r_s1.acnt;

    rshift_sticky u_rshift (
        .i_val    (w_field),
        .i_shamt  (w_shamt),
        .o_val    (w_shifted),
        .o_sticky (w_sticky)
    );

    always_comb begin
        w_s2          = '0;
        w_s2.pe       = r_s1.pe;
        w_s2.am       = w_neg ? w_field : w_shifted;
        w_s2.asticky  = ~w_neg & w_sticky;
        w_s2.killprod = w_neg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            if (w_en1) r_v1 <= io_bus.in_valid;
            if (w_en1 && io_bus.in_valid) r_s1 <= w_s1;
            if (w_en2) r_v2 <= r_v1;
            if (w_en2 && r_v1) r_s2 <= w_s2;
        end
    end

    assign io_bus.out_valid = r_v2;
    assign io_bus.Pe        = r_s2.pe;
    assign io_bus.Am        = r_s2.am;
    assign io_bus.ASticky   = r_s2.asticky;
    assign io_bus.KillProd  = r_s2.killprod;

endmodule

// File: tb/tb_fma16_align.sv
// Self-checking bench for fma16_align: arithmetic reference model with in-order scoreboard,
// plus literal expectations for the hand-worked vectors.
module tb_fma16_align;

`ifdef FMA16_ALIGN_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic clk;
    logic reset_n;

    fma16_align_if bus();

    fma16_align dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  pe;
        logic [35:0] am;
        logic        st;
        logic        kill;
        int          t;
    } exp_t;

    exp_t        q[$];
    int          n_chk     = 0;
    int          n_pass    = 0;
    int          n_out     = 0;
    int          n_blocked = 0;
    int          ncyc      = 0;
    int          last_pop  = -100;
    bit          head_seen = 1'b0;
    bit          prev_stall = 1'b0;
    logic [6:0]  prev_pe;
    logic [35:0] prev_am;
    logic        prev_st;
    logic        prev_kill;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    endtask

    // Reference: straight integer arithmetic on exponents and a 36-bit field value
    function automatic exp_t model(input int xe, input int ye, input int ze, input int zm, input int t);
        exp_t   e;
        int     pe;
        int     ac;
        longint f;
        pe     = xe + ye - 15;
        ac     = pe - ze + 12;
        f      = longint'(zm) * 64'd33554432;
        e.pe   = 7'(pe);
        e.t    = t;
        e.kill = 1'b0;
        if (ac < 0) begin
            e.am = 36'(f);
            e.st = 1'b0;
            e.kill = 1'b1;
        end else if (ac > 35) begin
            e.am = '0;
            e.st = (zm != 0);
        end else begin
            e.am = 36'(f >> ac);
            e.st = ((f % (longint'(1) << ac)) != 0);
        end
`ifndef FMA16_ALIGN_STICKY_EN
        e.st = 1'b0;
`endif
        return e;
    endfunction

    // Compare process: every negedge, check handshake and outputs against the scoreboard
    always @(negedge clk) begin
        int due;
        exp_t e;
        ncyc++;
        if (!reset_n) begin
            q.delete();
            last_pop   = -100;
            head_seen  = 1'b0;
            prev_stall = 1'b0;
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_am", 64'(bus.Am), 64'd0);
        end else begin
            chk("in_ready", 64'(bus.in_ready), 64'((q.size() == 2 && !bus.out_ready) ? 0 : 1));
            if (bus.in_valid && !bus.in_ready) n_blocked++;
            due = 0;
            if (q.size() > 0)
                due = (q[0].t + 2 > last_pop + 1) ? q[0].t + 2 : last_pop + 1;
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("stale_out_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = q[0];
                    chk("pe", 64'(bus.Pe), 64'(e.pe));
                    chk("am", 64'(bus.Am), 64'(e.am));
                    chk("asticky", 64'(bus.ASticky), 64'(e.st));
                    chk("killprod", 64'(bus.KillProd), 64'(e.kill));
                    if (!head_seen) begin
                        chk("latency_cycle", 64'(ncyc), 64'(due));
                        head_seen = 1'b1;
                    end
                    if (prev_stall) begin
                        chk("stall_pe", 64'(bus.Pe), 64'(prev_pe));
                        chk("stall_am", 64'(bus.Am), 64'(prev_am));
                        chk("stall_st", 64'(bus.ASticky), 64'(prev_st));
                        chk("stall_kill", 64'(bus.KillProd), 64'(prev_kill));
                    end
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        last_pop  = ncyc;
                        head_seen = 1'b0;
                        n_out++;
                    end
                end
            end else if (q.size() > 0 && ncyc >= due) begin
                chk("missing_out_valid", 64'(bus.out_valid), 64'd1);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_pe    = bus.Pe;
            prev_am    = bus.Am;
            prev_st    = bus.ASticky;
            prev_kill  = bus.KillProd;
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(int'(bus.Xe), int'(bus.Ye), int'(bus.Ze), int'(bus.Zm), ncyc));
        end
    end

    task automatic drive(input int xe, input int ye, input int ze, input int zm);
        bus.Xe = 5'(xe);
        bus.Ye = 5'(ye);
        bus.Ze = 5'(ze);
        bus.Zm = 11'(zm);
    endtask

    // Single op with exact-latency literal checks
    task automatic send_wait(input string nm, input int xe, input int ye, input int ze, input int zm,
                             input logic [6:0] epe, input logic [35:0] eam, input logic est,
                             input logic ekill);
        @(posedge clk); #1;
        drive(xe, ye, ze, zm);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_accept"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_early"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({nm, "_pe"}, 64'(bus.Pe), 64'(epe));
        chk({nm, "_am"}, 64'(bus.Am), 64'(eam));
        chk({nm, "_st"}, 64'(bus.ASticky), 64'(est));
        chk({nm, "_kill"}, 64'(bus.KillProd), 64'(ekill));
    endtask

    task automatic stream(input int v[][4]);
        for (int i = 0; i < v.size(); i++) begin
            @(posedge clk); #1;
            drive(v[i][0], v[i][1], v[i][2], v[i][3]);
            bus.in_valid = 1'b1;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus.in_ready) break;
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int bnd [][4];
        int bp  [][4];
        int base_out;
        int base_blk;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pe", 64'(bus.Pe), 64'd0);
        chk("reset_kill", 64'(bus.KillProd), 64'd0);
        chk("reset_sticky", 64'(bus.ASticky), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(bus.in_ready), 64'd1);

        send_wait("one_plus_one", 15, 15, 15, 'h400, 7'h0F, 36'h000800000, 1'b0, 1'b0);
        send_wait("small_addend", 15, 15, 1, 'h401, 7'h0F, 36'h000000200, STK, 1'b0);
        send_wait("far_below", 30, 30, 1, 'h400, 7'h2D, 36'h0, STK, 1'b0);
        send_wait("dominates", 1, 1, 30, 'h5A5, 7'h73, 36'hB4A000000, 1'b0, 1'b1);
        send_wait("acnt35", 19, 19, 0, 'h7FF, 7'h17, 36'h000000001, STK, 1'b0);

        // Boundary counts 0, 36, -1, 59, -34 and a mid value, back to back
        bnd = '{'{15, 15, 27, 'h7FF}, '{20, 19, 0, 'h7FF}, '{15, 15, 28, 'h555},
                '{31, 31, 0, 'h400}, '{0, 0, 31, 'h7FF}, '{10, 12, 5, 'h6A3}};
        stream(bnd);
        repeat (4) @(posedge clk);

        // Backpressure: 4 ops, out_ready low for 3 cycles after the first out_valid
        base_out = n_out;
        base_blk = n_blocked;
        bp = '{'{15, 15, 15, 'h400}, '{16, 14, 3, 'h4F1}, '{1, 1, 30, 'h5A5}, '{25, 22, 2, 'h7C3}};
        fork
            stream(bp);
            begin
                int k;
                k = 0;
                do begin
                    @(posedge clk); #1;
                    k++;
                end while (!bus.out_valid && k < 40);
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (n_out - base_out >= 4) break;
        end
        chk("bp_delivered", 64'(n_out - base_out), 64'd4);
        chk("bp_in_ready_low", 64'(n_blocked > base_blk), 64'd1);
        chk("bp_queue_empty", 64'(q.size()), 64'd0);

        // Reset with both stages occupied
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(15, 15, 15, 'h400);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        drive(20, 10, 7, 'h7FF);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("full_before_reset", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_am", 64'(bus.Am), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        send_wait("after_reset", 30, 30, 1, 'h400, 7'h2D, 36'h0, STK, 1'b0);
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
